dmem_access_unit: RTL and testbench

- Memory-stage responder for pipeline load/store requests: accepts the memaccess_t request from M and drives a req/gnt/rvalid data bus.
- Performs byte-lane steering and load sign/zero extension.
- Holds the pipeline with stall_mem while a transaction is outstanding.
- Reports misaligned/illegal-size accesses and bus timeouts as a one-cycle fault.

---
 rtl/dmem_access_unit_pkg.sv | 44 ++++
 rtl/dmem_access_unit_lane_fmt.sv | 63 ++++++
 rtl/dmem_access_unit.sv | 147 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit.
//   memaccess_t  : M-stage memory access kind
//   dmem_state_t : access FSM state encoding
//   F3_*         : load/store size/sign encodings carried in funct3
//   access_legal : size/alignment legality of an access
package dmem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } memaccess_t;

  typedef logic [1:0] dmem_state_t;

  localparam dmem_state_t IDLE = 2'd0;
  localparam dmem_state_t REQ  = 2'd1;
  localparam dmem_state_t WAIT = 2'd2;
  localparam dmem_state_t DONE = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes only exist for loads; halves need even addresses,
  // words need word-aligned addresses.
  function automatic logic access_legal(input logic [2:0] f3,
                                        input logic [1:0] addr_lo,
                                        input logic       is_write);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !is_write;
      F3_H:    ok = !addr_lo[0];
      F3_HU:   ok = !is_write && !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_access_unit_lane_fmt.sv
// Combinational byte-lane steering for the data-memory access unit.
//   st_funct3/st_addr_lo/st_data : store size, address low bits, LSB-aligned data
//   st_be/st_wdata               : byte enables and lane-replicated store data
//   ld_funct3/ld_addr_lo/ld_word : load size/sign, address low bits, bus read word
//   ld_data                      : lane-selected, sign/zero-extended load result
module dmem_lane_fmt
  import dmem_access_unit_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_data;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      F3_W: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h000000, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0000, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage responder: turns M-stage load/store requests into a
// req/gnt/rvalid bus transaction, holding the pipeline while it is in flight.
//   clk, rst_n        : pipeline clock, async active-low reset
//   memaccess_m       : access kind (MEM_READ / MEM_WRITE, else no access)
//   funct3_m          : size/sign (B, H, W, BU, HU)
//   addr_m, wdata_m   : byte address, LSB-aligned store data
//   rdata_m           : extended load result, valid in DONE
//   stall_mem         : freeze F/D/E/M while a transaction is outstanding
//   fault             : misaligned/illegal size (same cycle) or timeout (in DONE)
//   bus_req/we/addr/be/wdata : registered bus request
//   bus_gnt, bus_rvalid, bus_rdata : bus handshake and read data
//
// state | meaning
// IDLE  | evaluate M-stage access; legal access stalls and launches request
// REQ   | bus_req held until bus_gnt
// WAIT  | granted, waiting for bus_rvalid
// DONE  | one unstalled cycle so M retires; timeout fault reported here
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  memaccess_t  memaccess_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic [31:0] rdata_m,
  output logic        stall_mem,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  // The counter never needs to hold TIMEOUT itself: the abort fires on the
  // edge where it would get there.
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  dmem_state_t      state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_fault;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;

  logic        access;
  logic        is_write;
  logic        legal;
  logic        start;
  logic        tmo_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign access   = (memaccess_m == MEM_READ) || (memaccess_m == MEM_WRITE);
  assign is_write = (memaccess_m == MEM_WRITE);
  assign legal    = access_legal(funct3_m, addr_m[1:0], is_write);
  assign start    = (state == IDLE) && access && legal;
  assign tmo_hit  = TMO_EN && (tmo_cnt == CNT_LAST);

  assign stall_mem = start || (state == REQ) || (state == WAIT);
  assign fault     = ((state == IDLE) && access && !legal) ||
                     ((state == DONE) && tmo_fault);

  dmem_lane_fmt u_lane_fmt (
    .st_funct3  (funct3_m),
    .st_addr_lo (addr_m[1:0]),
    .st_data    (wdata_m),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_word    (bus_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      tmo_fault  <= 1'b0;
      ld_funct3  <= 3'b000;
      ld_addr_lo <= 2'b00;
      rdata_m    <= 32'h0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'b0000;
      bus_wdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            tmo_cnt    <= '0;
            bus_req    <= 1'b1;
            bus_we     <= is_write;
            bus_addr   <= {addr_m[31:2], 2'b00};
            bus_be     <= st_be;
            bus_wdata  <= st_wdata;
            ld_funct3  <= funct3_m;
            ld_addr_lo <= addr_m[1:0];
          end
        end
        REQ: begin
          if (tmo_hit) begin
            state     <= DONE;
            bus_req   <= 1'b0;
            rdata_m   <= 32'h0;
            tmo_fault <= 1'b1;
          end else begin
            if (bus_gnt) begin
              state   <= WAIT;
              bus_req <= 1'b0;
            end
            if (TMO_EN) tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (tmo_hit) begin
            state     <= DONE;
            rdata_m   <= 32'h0;
            tmo_fault <= 1'b1;
          end else if (bus_rvalid) begin
            state   <= DONE;
            rdata_m <= bus_we ? 32'h0 : ld_data;
          end else if (TMO_EN) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          tmo_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  memaccess_t  memaccess_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic [31:0] rdata_m;
  logic        stall_mem;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } lane_vec_t;

  dmem_access_unit #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memaccess_m (memaccess_m),
    .funct3_m    (funct3_m),
    .addr_m      (addr_m),
    .wdata_m     (wdata_m),
    .rdata_m     (rdata_m),
    .stall_mem   (stall_mem),
    .fault       (fault),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    memaccess_m = MEM_NONE;
    funct3_m    = 3'b000;
    addr_m      = 32'h0;
    wdata_m     = 32'h0;
    bus_gnt     = 1'b0;
    bus_rvalid  = 1'b0;
    bus_rdata   = 32'h0;
  endtask

  task automatic drive_op(input memaccess_t k, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
    memaccess_m = k;
    funct3_m    = f3;
    addr_m      = a;
    wdata_m     = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    checks++; if ({bus_req, bus_we, stall_mem, fault} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl: got req/we/stall/fault=%b exp 0000", {bus_req, bus_we, stall_mem, fault}); end
    checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h exp 00000000", bus_addr); end
    checks++; if ({bus_be, bus_wdata} !== 36'h0) begin failures++; $display("FAIL reset_be_wdata: got %h/%h exp 0/00000000", bus_be, bus_wdata); end
    checks++; if (rdata_m !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h exp 00000000", rdata_m); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lb();
    int stall_cycles = 0;
    @(negedge clk); drive_op(MEM_READ, F3_B, 32'h0000_1003, 32'h0); #1;
    if (stall_mem) stall_cycles++;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL lb_req_idle: got %b exp 0", bus_req); end
    @(negedge clk); #1;
    if (stall_mem) stall_cycles++;
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL lb_req: got %b exp 1", bus_req); end
    checks++; if (bus_addr !== 32'h0000_1000) begin failures++; $display("FAIL lb_addr: got %h exp 00001000", bus_addr); end
    checks++; if ({bus_we, bus_be} !== 5'b0_1000) begin failures++; $display("FAIL lb_we_be: got %b exp 01000", {bus_we, bus_be}); end
    bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h80FF_FF00; #1;
    if (stall_mem) stall_cycles++;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL lb_req_wait: got %b exp 0", bus_req); end
    @(negedge clk); idle_inputs(); #1;
    if (stall_mem) stall_cycles++;
    checks++; if (rdata_m !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata: got %h exp ffffff80", rdata_m); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL lb_fault: got %b exp 0", fault); end
    @(negedge clk); #1;
    if (stall_mem) stall_cycles++;
    checks++; if (stall_cycles !== 3) begin failures++; $display("FAIL lb_stall_cycles: got %0d exp 3", stall_cycles); end
  endtask

  task automatic test_sh();
    @(negedge clk); drive_op(MEM_WRITE, F3_H, 32'h0000_2002, 32'h0000_ABCD); #1;
    checks++; if ({stall_mem, fault} !== 2'b10) begin failures++; $display("FAIL sh_idle_stall_fault: got %b exp 10", {stall_mem, fault}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if ({bus_req, bus_we, bus_be} !== 6'b11_1100) begin failures++; $display("FAIL sh_hold_%0d: got req/we/be=%b exp 111100", i, {bus_req, bus_we, bus_be}); end
      checks++; if ({bus_addr, bus_wdata} !== {32'h0000_2000, 32'hABCD_ABCD}) begin failures++; $display("FAIL sh_addr_wdata_%0d: got %h/%h exp 00002000/abcdabcd", i, bus_addr, bus_wdata); end
    end
    @(negedge clk); #1;
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL sh_req_at_gnt: got %b exp 1", bus_req); end
    bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1357_9BDF; #1;
    checks++; if ({bus_req, stall_mem} !== 2'b01) begin failures++; $display("FAIL sh_after_gnt: got req/stall=%b exp 01", {bus_req, stall_mem}); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if ({stall_mem, rdata_m} !== {1'b0, 32'h0}) begin failures++; $display("FAIL sh_done: got stall=%b rdata=%h exp 0/00000000", stall_mem, rdata_m); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    @(negedge clk); drive_op(MEM_READ, F3_W, 32'h0000_3001, 32'h0); #1;
    checks++; if ({fault, stall_mem, bus_req} !== 3'b100) begin failures++; $display("FAIL lw_misaligned: got fault/stall/req=%b exp 100", {fault, stall_mem, bus_req}); end
    @(negedge clk); drive_op(MEM_WRITE, F3_BU, 32'h0000_3000, 32'h55); #1;
    checks++; if ({fault, stall_mem, bus_req} !== 3'b100) begin failures++; $display("FAIL store_bu_illegal: got fault/stall/req=%b exp 100", {fault, stall_mem, bus_req}); end
    @(negedge clk); drive_op(memaccess_t'(2'b11), F3_W, 32'h0000_3001, 32'h0); #1;
    checks++; if ({fault, stall_mem, bus_req} !== 3'b000) begin failures++; $display("FAIL no_access_kind: got fault/stall/req=%b exp 000", {fault, stall_mem, bus_req}); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if ({fault, bus_req} !== 2'b00) begin failures++; $display("FAIL misaligned_after: got fault/req=%b exp 00", {fault, bus_req}); end
  endtask

  task automatic test_lanes();
    lane_vec_t v [8];
    v[0] = '{1'b0, F3_B,  32'h00, 32'h0,         32'h1234_5678, 4'b0001, 32'h0,         32'h0000_0078};
    v[1] = '{1'b0, F3_BU, 32'h01, 32'h0,         32'h0000_F000, 4'b0010, 32'h0,         32'h0000_00F0};
    v[2] = '{1'b0, F3_B,  32'h02, 32'h0,         32'h0080_0000, 4'b0100, 32'h0,         32'hFFFF_FF80};
    v[3] = '{1'b0, F3_H,  32'h00, 32'h0,         32'h0000_8001, 4'b0011, 32'h0,         32'hFFFF_8001};
    v[4] = '{1'b0, F3_H,  32'h02, 32'h0,         32'hFFFE_0000, 4'b1100, 32'h0,         32'hFFFF_FFFE};
    v[5] = '{1'b0, F3_W,  32'h04, 32'h0,         32'hCAFE_BABE, 4'b1111, 32'h0,         32'hCAFE_BABE};
    v[6] = '{1'b1, F3_B,  32'h11, 32'h0000_005A, 32'h5555_5555, 4'b0010, 32'h5A5A_5A5A, 32'h0};
    v[7] = '{1'b1, F3_W,  32'h20, 32'h89AB_CDEF, 32'h5555_5555, 4'b1111, 32'h89AB_CDEF, 32'h0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_op(v[i].we ? MEM_WRITE : MEM_READ, v[i].f3, v[i].addr, v[i].wd);
      @(negedge clk); #1;
      checks++; if ({bus_req, bus_we, bus_be} !== {1'b1, v[i].we, v[i].be}) begin failures++; $display("FAIL lane_%0d_req_we_be: got %b exp %b", i, {bus_req, bus_we, bus_be}, {1'b1, v[i].we, v[i].be}); end
      checks++; if (bus_addr !== {v[i].addr[31:2], 2'b00}) begin failures++; $display("FAIL lane_%0d_addr: got %h exp %h", i, bus_addr, {v[i].addr[31:2], 2'b00}); end
      if (v[i].we) begin
        checks++; if (bus_wdata !== v[i].exp_wd) begin failures++; $display("FAIL lane_%0d_wdata: got %h exp %h", i, bus_wdata, v[i].exp_wd); end
      end
      bus_gnt = 1'b1;
      @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = v[i].rd;
      @(negedge clk); idle_inputs(); #1;
      checks++; if (rdata_m !== v[i].exp_rd) begin failures++; $display("FAIL lane_%0d_rdata: got %h exp %h", i, rdata_m, v[i].exp_rd); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive_op(MEM_READ, F3_HU, 32'h0000_4002, 32'h0);
    @(negedge clk); bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h9234_5678;
    @(negedge clk); bus_rvalid = 1'b0; drive_op(MEM_READ, F3_W, 32'h0000_5000, 32'h0); #1;
    checks++; if ({stall_mem, rdata_m} !== {1'b0, 32'h0000_9234}) begin failures++; $display("FAIL lhu_done: got stall=%b rdata=%h exp 0/00009234", stall_mem, rdata_m); end
    @(negedge clk); #1;
    checks++; if ({stall_mem, bus_req, fault} !== 3'b100) begin failures++; $display("FAIL b2b_idle_stall: got stall/req/fault=%b exp 100", {stall_mem, bus_req, fault}); end
    @(negedge clk); #1;
    checks++; if ({bus_req, bus_be, bus_addr} !== {1'b1, 4'b1111, 32'h0000_5000}) begin failures++; $display("FAIL b2b_lw_req: got req=%b be=%b addr=%h exp 1/1111/00005000", bus_req, bus_be, bus_addr); end
    bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk); idle_inputs(); #1;
    checks++; if (rdata_m !== 32'h1234_5678) begin failures++; $display("FAIL b2b_lw_rdata: got %h exp 12345678", rdata_m); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    @(negedge clk); drive_op(MEM_READ, F3_W, 32'h0000_6000, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (!bus_req) break;
      req_cycles++;
    end
    checks++; if (req_cycles !== 8) begin failures++; $display("FAIL tmo_req_cycles: got %0d exp 8", req_cycles); end
    checks++; if ({fault, stall_mem, bus_req} !== 3'b100) begin failures++; $display("FAIL tmo_done: got fault/stall/req=%b exp 100", {fault, stall_mem, bus_req}); end
    checks++; if (rdata_m !== 32'h0) begin failures++; $display("FAIL tmo_rdata: got %h exp 00000000", rdata_m); end
    idle_inputs();
    @(negedge clk); #1;
    checks++; if ({fault, stall_mem} !== 2'b00) begin failures++; $display("FAIL tmo_after: got fault/stall=%b exp 00", {fault, stall_mem}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive_op(MEM_READ, F3_B, 32'h0000_7000, 32'h0);
    @(negedge clk); bus_gnt = 1'b1;
    @(negedge clk); bus_gnt = 1'b0; #1;
    checks++; if (stall_mem !== 1'b1) begin failures++; $display("FAIL rst_mid_wait_stall: got %b exp 1", stall_mem); end
    rst_n = 1'b0; idle_inputs(); #1;
    checks++; if ({bus_req, bus_we, stall_mem, fault, bus_be} !== 8'h00) begin failures++; $display("FAIL rst_mid_ctrl: got %b exp 00000000", {bus_req, bus_we, stall_mem, fault, bus_be}); end
    checks++; if ({bus_addr, bus_wdata, rdata_m} !== 96'h0) begin failures++; $display("FAIL rst_mid_data: got %h/%h/%h exp zeros", bus_addr, bus_wdata, rdata_m); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    checks++; if ({stall_mem, fault, bus_req} !== 3'b000) begin failures++; $display("FAIL stale_rvalid_ctrl: got stall/fault/req=%b exp 000", {stall_mem, fault, bus_req}); end
    @(negedge clk); bus_rvalid = 1'b0; bus_rdata = 32'h0; #1;
    checks++; if ({stall_mem, bus_req, rdata_m} !== 34'h0) begin failures++; $display("FAIL stale_rvalid_after: got stall=%b req=%b rdata=%h exp 0/0/00000000", stall_mem, bus_req, rdata_m); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_lanes();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
